// File: rtl/dht11_responder_if.sv
// dht11_responder_if
// Groups the signals exchanged between the DHT11 responder and its
// surroundings. Clock and reset are not part of the interface.
//
//   enable            1 = answer host start pulses, 0 = stay idle, line released
//   dht_in            line value read back from the bidirectional buffer
//   humidity_int      frame byte 0
//   humidity_dec      frame byte 1
//   temp_int          frame byte 2
//   temp_dec          frame byte 3
//   corrupt_checksum  1 = send the inverted checksum
//   dht_drive_low     1 = pull the line low, 0 = release it (high-Z)
//   busy              responder is anywhere but IDLE
//   frame_done        one-cycle pulse after the end marker of a frame
//
// master: the side that owns the line and the data registers.
// slave : the responder itself.
interface dht11_responder_if;
  logic       enable;
  logic       dht_in;
  logic [7:0] humidity_int;
  logic [7:0] humidity_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_checksum;
  logic       dht_drive_low;
  logic       busy;
  logic       frame_done;

  modport master (
    output enable, dht_in, humidity_int, humidity_dec, temp_int, temp_dec,
           corrupt_checksum,
    input  dht_drive_low, busy, frame_done
  );

  modport slave (
    input  enable, dht_in, humidity_int, humidity_dec, temp_int, temp_dec,
           corrupt_checksum,
    output dht_drive_low, busy, frame_done
  );
endinterface

// File: rtl/dht11_responder.sv
// dht11_responder
// Sensor-side emulation of the DHT11 single-wire protocol. Waits for the
// host start pulse on the open-drain line, then answers with the response
// preamble followed by a 40-bit frame (humidity_int, humidity_dec,
// temp_int, temp_dec, checksum; each byte MSB first). The line is only
// ever pulled low; a pull-up provides the high level.
//
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   bus    dht11_responder_if.slave (enable, dht_in, data bytes,
//          corrupt_checksum in; dht_drive_low, busy, frame_done out)
module dht11_responder #(
  parameter int TICKS_PER_US = 50,
  parameter int START_MIN_US = 18000,
  parameter int RESP_WAIT_US = 30,
  parameter int RESP_LOW_US  = 80,
  parameter int RESP_HIGH_US = 80,
  parameter int BIT_LOW_US   = 50,
  parameter int BIT0_HIGH_US = 27,
  parameter int BIT1_HIGH_US = 70
) (
  input  logic            clock,
  input  logic            reset,
  dht11_responder_if.slave bus
);

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_US = max_int(max_int(max_int(START_MIN_US, RESP_WAIT_US),
                                          max_int(RESP_LOW_US, RESP_HIGH_US)),
                                  max_int(max_int(BIT_LOW_US, BIT0_HIGH_US),
                                          BIT1_HIGH_US));
  localparam int US_W  = $clog2(MAX_US + 1);
  localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST       = PRE_W'(TICKS_PER_US - 1);
  localparam logic [US_W-1:0]  US_MAX         = {US_W{1'b1}};
  localparam logic [US_W-1:0]  START_MIN      = US_W'(START_MIN_US);
  // A phase of N us ends on the last prescaler tick of microsecond N-1.
  localparam logic [US_W-1:0]  LAST_WAIT      = US_W'(RESP_WAIT_US - 1);
  localparam logic [US_W-1:0]  LAST_RESP_LOW  = US_W'(RESP_LOW_US - 1);
  localparam logic [US_W-1:0]  LAST_RESP_HIGH = US_W'(RESP_HIGH_US - 1);
  localparam logic [US_W-1:0]  LAST_BIT_LOW   = US_W'(BIT_LOW_US - 1);
  localparam logic [US_W-1:0]  LAST_BIT0_HIGH = US_W'(BIT0_HIGH_US - 1);
  localparam logic [US_W-1:0]  LAST_BIT1_HIGH = US_W'(BIT1_HIGH_US - 1);

  typedef enum logic [3:0] {
    IDLE,
    HOST_START,
    RESP_WAIT,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW,
    DONE
  } state_t;

  state_t           state_reg;
  logic             sync1_reg;
  logic             line_s_reg;
  logic [PRE_W-1:0] pre_reg;
  logic [US_W-1:0]  us_reg;
  logic [39:0]      shift_reg;
  logic [5:0]       bit_idx_reg;
  logic             drive_low_reg;
  logic             busy_reg;
  logic             frame_done_reg;

  logic             tick_wrap;
  logic [US_W-1:0]  phase_last;
  logic             phase_end;
  logic [7:0]       checksum;

  // Two-flop synchronizer. Resets to 1 (idle bus level) so that leaving
  // reset never looks like a host start pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg  <= 1'b1;
      line_s_reg <= 1'b1;
    end else begin
      sync1_reg  <= bus.dht_in;
      line_s_reg <= sync1_reg;
    end
  end

  always_comb begin
    tick_wrap = (pre_reg == PRE_LAST);
    phase_last = '0;
    case (state_reg)
      RESP_WAIT:        phase_last = LAST_WAIT;
      RESP_LOW:         phase_last = LAST_RESP_LOW;
      RESP_HIGH:        phase_last = LAST_RESP_HIGH;
      BIT_LOW, END_LOW: phase_last = LAST_BIT_LOW;
      BIT_HIGH:         phase_last = shift_reg[39] ? LAST_BIT1_HIGH : LAST_BIT0_HIGH;
      default:          phase_last = '0;
    endcase
    phase_end = tick_wrap && (us_reg == phase_last);
    // 8-bit sum wraps naturally; inversion is the error-injection path.
    checksum = (bus.humidity_int + bus.humidity_dec + bus.temp_int + bus.temp_dec)
               ^ {8{bus.corrupt_checksum}};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pre_reg        <= '0;
      us_reg         <= '0;
      shift_reg      <= '0;
      bit_idx_reg    <= '0;
      drive_low_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;

      // Free-running timebase; each state change below clears it again,
      // so every timed state starts from 0 us / tick 0.
      if (tick_wrap) begin
        pre_reg <= '0;
        if (us_reg != US_MAX) begin
          us_reg <= us_reg + 1'b1;
        end
      end else begin
        pre_reg <= pre_reg + 1'b1;
      end

      if (!bus.enable) begin
        state_reg     <= IDLE;
        drive_low_reg <= 1'b0;
        busy_reg      <= 1'b0;
        pre_reg       <= '0;
        us_reg        <= '0;
        bit_idx_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            pre_reg <= '0;
            us_reg  <= '0;
            if (!line_s_reg) begin
              state_reg <= HOST_START;
              busy_reg  <= 1'b1;
            end
          end

          HOST_START: begin
            // us_reg saturates, so an arbitrarily long host low is fine.
            if (line_s_reg) begin
              pre_reg <= '0;
              us_reg  <= '0;
              if (us_reg >= START_MIN) begin
                state_reg   <= RESP_WAIT;
                // Frame contents are frozen here; later input changes
                // do not reach a frame in progress.
                shift_reg   <= {bus.humidity_int, bus.humidity_dec,
                                bus.temp_int, bus.temp_dec, checksum};
                bit_idx_reg <= '0;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end
          end

          RESP_WAIT: begin
            if (phase_end) begin
              state_reg     <= RESP_LOW;
              drive_low_reg <= 1'b1;
              pre_reg       <= '0;
              us_reg        <= '0;
            end
          end

          RESP_LOW: begin
            if (phase_end) begin
              state_reg     <= RESP_HIGH;
              drive_low_reg <= 1'b0;
              pre_reg       <= '0;
              us_reg        <= '0;
            end
          end

          RESP_HIGH: begin
            if (phase_end) begin
              state_reg     <= BIT_LOW;
              drive_low_reg <= 1'b1;
              pre_reg       <= '0;
              us_reg        <= '0;
            end
          end

          BIT_LOW: begin
            if (phase_end) begin
              state_reg     <= BIT_HIGH;
              drive_low_reg <= 1'b0;
              pre_reg       <= '0;
              us_reg        <= '0;
            end
          end

          BIT_HIGH: begin
            if (phase_end) begin
              shift_reg     <= {shift_reg[38:0], 1'b0};
              bit_idx_reg   <= bit_idx_reg + 1'b1;
              drive_low_reg <= 1'b1;
              pre_reg       <= '0;
              us_reg        <= '0;
              state_reg     <= (bit_idx_reg == 6'd39) ? END_LOW : BIT_LOW;
            end
          end

          END_LOW: begin
            if (phase_end) begin
              state_reg      <= DONE;
              drive_low_reg  <= 1'b0;
              frame_done_reg <= 1'b1;
              pre_reg        <= '0;
              us_reg         <= '0;
            end
          end

          DONE: begin
            // Our own end-marker low is still in the synchronizer; wait
            // for the line to read high so it is not taken as a new start.
            if (line_s_reg) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end

          default: begin
            state_reg     <= IDLE;
            drive_low_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.dht_drive_low = drive_low_reg;
  assign bus.busy          = busy_reg;
  assign bus.frame_done    = frame_done_reg;

endmodule

// File: tb/tb_dht11_responder.sv
// tb_dht11_responder
// Directed bench for dht11_responder with a scaled timebase (2 cycles/us,
// 200 us minimum start pulse). Plays the host on the open-drain line,
// measures every phase in clock cycles and decodes the 40-bit frame.
module tb_dht11_responder;
  localparam int T       = 2;
  localparam int S       = 200;
  localparam int WAIT_US = 30;
  localparam int RLOW_US = 80;
  localparam int RHI_US  = 80;
  localparam int BLOW_US = 50;
  localparam int B0_US   = 27;
  localparam int B1_US   = 70;
  localparam int CAP     = 1000;

  logic clock = 1'b0;
  logic reset;
  logic host_low;
  int   n_compared   = 0;
  int   n_mismatched = 0;
  int   done_count   = 0;

  dht11_responder_if bus();

  dht11_responder #(
    .TICKS_PER_US(T),
    .START_MIN_US(S)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  // Open-drain line with pull-up: low if either side pulls it low.
  assign bus.dht_in = ~(bus.dht_drive_low | host_low);

  always @(negedge clock) begin
    if (bus.frame_done === 1'b1) done_count++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Number of consecutive negedge samples (starting now) at which
  // dht_drive_low equals level; returns positioned at the first other sample.
  task automatic measure(input logic level, output int len);
    len = 0;
    while (bus.dht_drive_low === level && len < CAP) begin
      len++;
      @(negedge clock);
    end
  endtask

  // Host pulls low for us microseconds and releases at a negedge.
  task automatic host_start(input string tag, input int us);
    host_low = 1'b1;
    repeat (2) @(negedge clock);
    check({tag, ":busy_before_sync"}, bus.busy, 1'b0);
    @(negedge clock);
    check({tag, ":busy_after_sync"}, bus.busy, 1'b1);
    repeat (us * T - 3) @(negedge clock);
    host_low = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int host_us, input logic [39:0] exp,
                           input int abort_bit, input int poke_bit);
    logic [39:0] got;
    int len, bad_low, bad_high, d0;
    d0 = done_count;
    host_start(tag, host_us);
    measure(1'b0, len); check({tag, ":resp_wait"}, len, WAIT_US * T + 3);
    measure(1'b1, len); check({tag, ":resp_low"},  len, RLOW_US * T);
    measure(1'b0, len); check({tag, ":resp_high"}, len, RHI_US * T);
    got = '0; bad_low = 0; bad_high = 0;
    for (int b = 0; b < 40; b++) begin
      if (b == abort_bit) begin
        bus.enable = 1'b0;
        @(negedge clock);
        check({tag, ":abort_release"}, bus.dht_drive_low, 1'b0);
        check({tag, ":abort_busy"}, bus.busy, 1'b0);
        repeat (400) @(negedge clock);
        check({tag, ":abort_no_done"}, done_count - d0, 0);
        check({tag, ":abort_still_released"}, bus.dht_drive_low, 1'b0);
        bus.enable = 1'b1;
        repeat (4) @(negedge clock);
        $display("frame %s: aborted at bit %0d", tag, b);
        return;
      end
      if (b == poke_bit) bus.temp_int = 8'h20;
      measure(1'b1, len);
      if (len != BLOW_US * T) bad_low++;
      measure(1'b0, len);
      if (len == B1_US * T)      got = {got[38:0], 1'b1};
      else if (len == B0_US * T) got = {got[38:0], 1'b0};
      else begin
        got = {got[38:0], 1'b0};
        bad_high++;
        if (len >= CAP) break;
      end
    end
    check({tag, ":bit_low_len_errors"},  bad_low,  0);
    check({tag, ":bit_high_len_errors"}, bad_high, 0);
    measure(1'b1, len); check({tag, ":end_low"}, len, BLOW_US * T);
    repeat (6) @(negedge clock);
    check({tag, ":busy_after_done"}, bus.busy, 1'b0);
    check({tag, ":frame_done_pulses"}, done_count - d0, 1);
    check({tag, ":hum_int"}, got[39:32], exp[39:32]);
    check({tag, ":hum_dec"}, got[31:24], exp[31:24]);
    check({tag, ":tmp_int"}, got[23:16], exp[23:16]);
    check({tag, ":tmp_dec"}, got[15:8],  exp[15:8]);
    check({tag, ":checksum"}, got[7:0],  exp[7:0]);
    $display("frame %s: decoded %h expected %h", tag, got, exp);
  endtask

  // Start pulse too short: the line must never be pulled low.
  task automatic run_reject(input string tag, input int host_us);
    int lows, d0;
    d0 = done_count;
    lows = 0;
    host_start(tag, host_us);
    repeat (1500) begin
      @(negedge clock);
      if (bus.dht_drive_low !== 1'b0) lows++;
    end
    check({tag, ":never_driven"}, lows, 0);
    check({tag, ":busy_idle"}, bus.busy, 1'b0);
    check({tag, ":no_done"}, done_count - d0, 0);
    $display("start %s: %0d us pulse, driven-low samples %0d", tag, host_us, lows);
  endtask

  initial begin
    int len;
    host_low             = 1'b0;
    bus.enable           = 1'b1;
    bus.humidity_int     = 8'h37;
    bus.humidity_dec     = 8'h00;
    bus.temp_int         = 8'h19;
    bus.temp_dec         = 8'h05;
    bus.corrupt_checksum = 1'b0;
    reset                = 1'b1;
    repeat (3) @(negedge clock);
    check("reset:drive_low",  bus.dht_drive_low, 1'b0);
    check("reset:busy",       bus.busy,          1'b0);
    check("reset:frame_done", bus.frame_done,    1'b0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    check("post_reset:busy", bus.busy, 1'b0);
    $display("reset: outputs drive_low=%b busy=%b frame_done=%b",
             bus.dht_drive_low, bus.busy, bus.frame_done);

    run_frame("normal", S + 20, 40'h37_00_19_05_55, 99, 99);
    run_reject("short", S / 4);
    run_reject("below_min", S - 2);

    bus.corrupt_checksum = 1'b1;
    run_frame("corrupt", S + 1, 40'h37_00_19_05_AA, 99, 99);
    bus.corrupt_checksum = 1'b0;

    run_frame("latch", S + 20, 40'h37_00_19_05_55, 99, 5);
    bus.temp_int = 8'h19;

    run_frame("abort", S + 20, 40'h37_00_19_05_55, 12, 99);
    run_frame("after_abort", S + 20, 40'h37_00_19_05_55, 99, 99);

    // Reset during the response low phase must release the line at once.
    host_start("reset_mid", S + 20);
    measure(1'b0, len);
    check("reset_mid:in_resp_low", bus.dht_drive_low, 1'b1);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    check("reset_mid:drive_low",  bus.dht_drive_low, 1'b0);
    check("reset_mid:busy",       bus.busy,          1'b0);
    check("reset_mid:frame_done", bus.frame_done,    1'b0);
    $display("reset_mid: async release drive_low=%b busy=%b", bus.dht_drive_low, bus.busy);
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    run_frame("after_reset", S + 20, 40'h37_00_19_05_55, 99, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
